// File: rtl/pbit_array.sv
// Array of N probabilistic bits: per-channel LFSR, beta-scaled hard-tanh activation
// and overflow-free sign compare, swept in parallel or sequential (Gibbs) order.
module pbit_array #(
  parameter int               N      = 8,
  parameter int               BIAS_W = 8,
  parameter int               RNG_W  = 16,
  parameter logic [RNG_W-1:0] SEED   = 16'hACE1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                en,
  input  logic                mode,
  input  logic [4:0]          beta,
  input  logic [N*BIAS_W-1:0] bias,
  input  logic                bias_valid,
  output logic                bias_ready,
  output logic [N-1:0]        state_out,
  output logic                sample_valid,
  output logic [15:0]         sweep_count
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int EXT_W = BIAS_W + RNG_W + 1;
  localparam int ACT_W = RNG_W + 1;
  localparam int SUM_W = RNG_W + 2;
  localparam logic [31:0] TAPS = (RNG_W == 32) ? 32'h8020_0003 : 32'h0000_B400;
  localparam logic signed [EXT_W-1:0] ACT_MAX = EXT_W'(1) <<< (RNG_W - 1);
  localparam logic signed [EXT_W-1:0] ACT_MIN = -ACT_MAX;

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t                fsm;
  logic [IDX_W-1:0]    idx;
  logic [N*BIAS_W-1:0] bias_q;
  logic [5:0]          beta_q;
  logic                mode_q;
  logic [RNG_W-1:0]    lfsr [N];
  logic signed [ACT_W-1:0] act [N];
  logic [N-1:0]        upd;

  // Saturation bound is +2^(RNG_W-1), one past signed max, so a saturated
  // positive activation beats every possible LFSR value.
  function automatic logic signed [ACT_W-1:0] activate(input logic signed [BIAS_W-1:0] b,
                                                       input logic [5:0] sh);
    logic signed [EXT_W-1:0] ext;
    ext = {{(EXT_W-BIAS_W){b[BIAS_W-1]}}, b};
    ext = ext <<< sh;
    if (ext > ACT_MAX) return ACT_W'(ACT_MAX);
    if (ext < ACT_MIN) return ACT_W'(ACT_MIN);
    return ACT_W'(ext);
  endfunction

  function automatic logic sample(input logic signed [ACT_W-1:0] a,
                                  input logic signed [RNG_W-1:0] r);
    logic signed [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(r);
    return ~s[SUM_W-1];
  endfunction

  function automatic logic [RNG_W-1:0] lfsr_next(input logic [RNG_W-1:0] l);
    return {l[RNG_W-2:0], ^(l & TAPS[RNG_W-1:0])};
  endfunction

  function automatic logic [RNG_W-1:0] seed_of(input int i);
    int k;
    k = i % RNG_W;
    return (SEED << k) | (SEED >> (RNG_W - k));
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_act
    assign act[g] = activate(bias_q[g*BIAS_W +: BIAS_W], beta_q);
  end

  always_comb begin
    upd = '0;
    for (int i = 0; i < N; i++)
      upd[i] = (fsm == RUN) && en && (!mode_q || (idx == IDX_W'(i)));
  end

  assign bias_ready = (fsm == IDLE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fsm          <= IDLE;
      idx          <= '0;
      bias_q       <= '0;
      beta_q       <= '0;
      mode_q       <= 1'b0;
      state_out    <= '0;
      sample_valid <= 1'b0;
      sweep_count  <= '0;
      for (int i = 0; i < N; i++) lfsr[i] <= seed_of(i);
    end else begin
      sample_valid <= 1'b0;
      case (fsm)
        IDLE: begin
          if (bias_valid) begin
            bias_q <= bias;
            mode_q <= mode;
            beta_q <= ({1'b0, beta} > 6'(RNG_W)) ? 6'(RNG_W) : {1'b0, beta};
            idx    <= '0;
            fsm    <= RUN;
          end
        end
        RUN: begin
          if (en) begin
            // Compare uses the pre-advance LFSR value of each updated channel.
            for (int i = 0; i < N; i++) begin
              if (upd[i]) begin
                state_out[i] <= sample(act[i], lfsr[i]);
                lfsr[i]      <= lfsr_next(lfsr[i]);
              end
            end
            if (!mode_q || (idx == IDX_W'(N - 1))) begin
              fsm          <= DONE;
              idx          <= '0;
              sample_valid <= 1'b1;
              sweep_count  <= sweep_count + 16'd1;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        DONE:    fsm <= IDLE;
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pbit_array.sv
// Directed bench for pbit_array (N=8, BIAS_W=8, RNG_W=16) with an integer-arithmetic
// reference for the LFSR streams and the sample decision.
module tb_pbit_array;
  localparam int N = 8;
  localparam int BIAS_W = 8;
  localparam int RNG_W = 16;

  logic                CLK = 1'b0;
  logic                RST;
  logic                en;
  logic                mode;
  logic [4:0]          beta;
  logic [N*BIAS_W-1:0] bias;
  logic                bias_valid;
  logic                bias_ready;
  logic [N-1:0]        state_out;
  logic                sample_valid;
  logic [15:0]         sweep_count;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0]  m_lfsr [N];
  logic [N-1:0] m_state;
  int           m_count;

  pbit_array #(.N(N), .BIAS_W(BIAS_W), .RNG_W(RNG_W), .SEED(16'hACE1)) dut (
    .CLK(CLK), .RST(RST), .en(en), .mode(mode), .beta(beta), .bias(bias),
    .bias_valid(bias_valid), .bias_ready(bias_ready), .state_out(state_out),
    .sample_valid(sample_valid), .sweep_count(sweep_count)
  );

  always #5 CLK = ~CLK;

  task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] m_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic m_sample(input logic [7:0] b, input int sh, input logic [15:0] r);
    longint a;
    int k;
    k = (sh > 16) ? 16 : sh;
    a = longint'($signed(b)) * (longint'(1) << k);
    if (a > 32768) a = 32768;
    if (a < -32768) a = -32768;
    return (a + longint'($signed(r))) >= 0;
  endfunction

  task automatic m_reset();
    logic [15:0] s;
    s = 16'hACE1;
    for (int i = 0; i < N; i++) begin
      m_lfsr[i] = s;
      s = {s[14:0], s[15]};
    end
    m_state = '0;
    m_count = 0;
  endtask

  task automatic m_update(input int i, input logic [N*BIAS_W-1:0] b, input int bt);
    m_state[i] = m_sample(b[i*BIAS_W +: BIAS_W], bt, m_lfsr[i]);
    m_lfsr[i]  = m_next(m_lfsr[i]);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic accept(input logic [N*BIAS_W-1:0] b, input logic md, input logic [4:0] bt);
    bias = b; mode = md; beta = bt; bias_valid = 1'b1;
    tick();
    bias_valid = 1'b0;
  endtask

  task automatic par_sweep(input string tag, input logic [N*BIAS_W-1:0] b,
                           input logic [4:0] bt, input logic [N-1:0] exp_state);
    accept(b, 1'b0, bt);
    check_vec({tag, "_busy"}, {bias_ready, sample_valid}, 2'b00);
    for (int i = 0; i < N; i++) m_update(i, b, int'(bt));
    m_count++;
    tick();
    check_vec({tag, "_valid"}, sample_valid, 1'b1);
    check_vec({tag, "_state"}, state_out, exp_state);
    check_vec({tag, "_count"}, sweep_count, 16'(m_count));
    tick();
    check_vec({tag, "_idle"}, {bias_ready, sample_valid}, 2'b10);
  endtask

  initial begin
    logic [N-1:0] exp_s;
    logic [N-1:0] mask;
    int ones [N];
    int agree [N][N];
    int mism;

    RST = 1'b1; en = 1'b1; mode = 1'b0; beta = '0; bias = '0; bias_valid = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    m_reset();
    check_vec("rst_state", state_out, '0);
    check_vec("rst_valid", sample_valid, 1'b0);
    check_vec("rst_count", sweep_count, 16'd0);
    check_vec("rst_ready", bias_ready, 1'b1);
    check_vec("rst_lfsr0", dut.lfsr[0], 16'hACE1);

    // saturating biases: +127<<9 and -128<<8 (exactly the lower bound)
    par_sweep("par_pos", {N{8'h7F}}, 5'd9, 8'hFF);
    par_sweep("par_neg", {N{8'h80}}, 5'd8, 8'h00);
    // beta 31 must clamp to 16 so +/-1 saturates
    par_sweep("par_clamp", {4{8'hFF, 8'h01}}, 5'd31, 8'h55);

    // sequential sweep, previous vector 0x55, target 0xAA
    accept({4{8'h7F, 8'h80}}, 1'b1, 5'd16);
    check_vec("seq_busy", bias_ready, 1'b0);
    for (int k = 0; k < N; k++) begin
      m_update(k, {4{8'h7F, 8'h80}}, 16);
      tick();
      mask  = N'((1 << (k + 1)) - 1);
      exp_s = (8'hAA & mask) | (8'h55 & ~mask);
      check_vec($sformatf("seq_state%0d", k), state_out, exp_s);
      check_vec($sformatf("seq_valid%0d", k), sample_valid, (k == N - 1));
    end
    m_count++;
    check_vec("seq_count", sweep_count, 16'(m_count));
    tick();
    check_vec("seq_idle", {bias_ready, sample_valid}, 2'b10);

    // sequential sweep with a 3-cycle enable stall after channel 2, target 0x55
    accept({4{8'h80, 8'h7F}}, 1'b1, 5'd16);
    for (int k = 0; k < 3; k++) begin
      m_update(k, {4{8'h80, 8'h7F}}, 16);
      tick();
    end
    exp_s = 8'hAD;
    check_vec("stall_pre", state_out, exp_s);
    en = 1'b0;
    bias = {N{8'h7F}}; mode = 1'b0; bias_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_vec($sformatf("stall_state%0d", c), state_out, exp_s);
      check_vec($sformatf("stall_idx%0d", c), dut.idx, 3);
      check_vec($sformatf("stall_lfsr%0d", c), {dut.lfsr[2], dut.lfsr[3]}, {m_lfsr[2], m_lfsr[3]});
      check_vec($sformatf("stall_flags%0d", c), {bias_ready, sample_valid}, 2'b00);
    end
    en = 1'b1; bias_valid = 1'b0;
    for (int k = 3; k < N; k++) begin
      m_update(k, {4{8'h80, 8'h7F}}, 16);
      tick();
      check_vec($sformatf("stall_valid%0d", k), sample_valid, (k == N - 1));
    end
    m_count++;
    check_vec("stall_final", state_out, 8'h55);
    check_vec("stall_count", sweep_count, 16'(m_count));
    tick();
    check_vec("stall_done", sample_valid, 1'b0);

    // unbiased statistics over 2048 parallel sweeps
    for (int i = 0; i < N; i++) begin
      ones[i] = 0;
      for (int j = 0; j < N; j++) agree[i][j] = 0;
    end
    mism = 0;
    for (int s = 0; s < 2048; s++) begin
      accept('0, 1'b0, 5'd0);
      for (int i = 0; i < N; i++) m_update(i, '0, 0);
      tick();
      if (state_out !== m_state || sample_valid !== 1'b1) mism++;
      for (int i = 0; i < N; i++) begin
        if (state_out[i]) ones[i]++;
        for (int j = i + 1; j < N; j++)
          if (state_out[i] == state_out[j]) agree[i][j]++;
      end
      tick();
    end
    m_count += 2048;
    check_vec("rand_model", mism, 0);
    check_vec("rand_count", sweep_count, 16'(m_count));
    for (int i = 0; i < N; i++)
      check_vec($sformatf("rand_ones%0d(%0d)", i, ones[i]), (ones[i] >= 924 && ones[i] <= 1124), 1'b1);
    for (int i = 0; i < N; i++)
      for (int j = i + 1; j < N; j++)
        check_vec($sformatf("rand_agree%0d_%0d(%0d)", i, j, agree[i][j]),
                  (agree[i][j] >= 924 && agree[i][j] <= 1124), 1'b1);

    // asynchronous reset at idx=4 of a sequential sweep
    accept({4{8'h7F, 8'h80}}, 1'b1, 5'd16);
    repeat (4) tick();
    check_vec("abort_idx", dut.idx, 4);
    #3;
    RST = 1'b1;
    #1;
    check_vec("abort_state", state_out, '0);
    check_vec("abort_flags", {bias_ready, sample_valid}, 2'b10);
    check_vec("abort_count", sweep_count, 16'd0);
    check_vec("abort_lfsr0", dut.lfsr[0], 16'hACE1);
    tick();
    check_vec("abort_hold", {sample_valid, sweep_count}, 17'd0);
    RST = 1'b0;
    m_reset();
    for (int s = 0; s < 4; s++) begin
      accept('0, 1'b0, 5'd0);
      for (int i = 0; i < N; i++) m_update(i, '0, 0);
      m_count++;
      tick();
      check_vec($sformatf("post_state%0d", s), state_out, m_state);
      check_vec($sformatf("post_count%0d", s), sweep_count, 16'(m_count));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
